// File: rtl/parser_cfg_pkt_gen_pkg.sv
// Shared constants, FSM encoding and byte-swap helper for the parser
// action-RAM control packet generator.
package parser_cfg_pkg;

  localparam int MOD_ID_LSB   = 112;
  localparam int ADDR_MSB     = 248;
  localparam int DLO_DATA_MSB = 239;
  localparam int PKT_BYTES    = 128;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_HDR  = 3'd1;
  localparam logic [2:0] ST_MOD  = 3'd2;
  localparam logic [2:0] ST_DHI  = 3'd3;
  localparam logic [2:0] ST_DLO  = 3'd4;
  localparam logic [2:0] ST_GAP  = 3'd5;

  // Reverse the 32 bytes of a 256-bit word: byte k <-> byte 31-k.
  function automatic logic [255:0] bswap256(input logic [255:0] w);
    logic [255:0] r;
    r = '0;
    for (int k = 0; k < 32; k++) begin
      r[8*k +: 8] = w[255-8*k -: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/parser_cfg_pkt_gen_if.sv
// AXI-Stream control bus carrying the generated parser config packets.
interface parser_cfg_pkt_gen_if #(
  parameter int DATA_WIDTH  = 256,
  parameter int TUSER_WIDTH = 128
);

  logic [DATA_WIDTH-1:0]   tdata;
  logic [TUSER_WIDTH-1:0]  tuser;
  logic [DATA_WIDTH/8-1:0] tkeep;
  logic                    tvalid;
  logic                    tlast;
  logic                    tready;

  modport master (
    output tdata, tuser, tkeep, tvalid, tlast,
    input  tready
  );

  modport slave (
    input  tdata, tuser, tkeep, tvalid, tlast,
    output tready
  );

endinterface

// File: rtl/parser_cfg_pkt_gen.sv
// Turns one parser action-RAM write request into a 4-beat AXIS control packet
// (header, module ID, upper instructions, address + lower instructions).
module parser_cfg_pkt_gen
  import parser_cfg_pkg::*;
#(
  parameter int C_AXIS_DATA_WIDTH  = 256,
  parameter int C_AXIS_TUSER_WIDTH = 128,
  parameter int C_PARSER_RAM_WIDTH = 384,
  parameter int RAM_ADDR_WIDTH     = 9,
  parameter int IFG_CYCLES         = 2,
  parameter logic [C_AXIS_DATA_WIDTH-1:0] CTRL_HDR = 256'h0
) (
  input  logic                          axis_clk,
  input  logic                          aresetn,
  input  logic                          i_cfg_valid,
  output logic                          o_cfg_ready,
  input  logic [3:0]                    i_cfg_mod_id,
  input  logic [RAM_ADDR_WIDTH-1:0]     i_cfg_addr,
  input  logic [C_PARSER_RAM_WIDTH-1:0] i_cfg_data,
  parser_cfg_pkt_gen_if.master          ctrl_m_axis,
  output logic                          o_busy,
  output logic [15:0]                   o_pkt_cnt
);

  localparam int KEEP_WIDTH = C_AXIS_DATA_WIDTH / 8;
  localparam int LO_WIDTH   = C_PARSER_RAM_WIDTH - C_AXIS_DATA_WIDTH;
  localparam logic [7:0] GAP_LOAD = 8'(IFG_CYCLES - 1);
  localparam logic [C_AXIS_TUSER_WIDTH-1:0] HDR_TUSER =
    {{(C_AXIS_TUSER_WIDTH-16){1'b0}}, 16'(PKT_BYTES)};

  logic [2:0]                    state_r;
  logic [7:0]                    gap_cnt_r;
  logic [3:0]                    mod_r;
  logic [RAM_ADDR_WIDTH-1:0]     addr_r;
  logic [C_PARSER_RAM_WIDTH-1:0] data_r;
  logic [C_AXIS_DATA_WIDTH-1:0]  tdata_r;
  logic [C_AXIS_TUSER_WIDTH-1:0] tuser_r;
  logic [KEEP_WIDTH-1:0]         tkeep_r;
  logic                          tvalid_r;
  logic                          tlast_r;
  logic                          cfg_ready_r;
  logic                          busy_r;
  logic [15:0]                   pkt_cnt_r;

  logic [C_AXIS_DATA_WIDTH-1:0]  mod_beat_s;
  logic [C_AXIS_DATA_WIDTH-1:0]  dhi_beat_s;
  logic [C_AXIS_DATA_WIDTH-1:0]  dlo_word_s;
  logic [C_AXIS_DATA_WIDTH-1:0]  dlo_beat_s;
  logic                          hs_s;
  logic                          accept_s;

  assign hs_s     = tvalid_r & ctrl_m_axis.tready;
  assign accept_s = i_cfg_valid & cfg_ready_r;

  // Next-beat payloads built from the captured request only.
  always_comb begin
    mod_beat_s = '0;
    mod_beat_s[MOD_ID_LSB +: 4] = mod_r;
    dlo_word_s = '0;
    dlo_word_s[ADDR_MSB -: RAM_ADDR_WIDTH] = addr_r;
    dlo_word_s[DLO_DATA_MSB -: LO_WIDTH]   = data_r[LO_WIDTH-1:0];
    dhi_beat_s = bswap256(data_r[C_PARSER_RAM_WIDTH-1 -: C_AXIS_DATA_WIDTH]);
    dlo_beat_s = bswap256(dlo_word_s);
  end

  // Request capture, packet FSM and the registered output beat.
  always_ff @(posedge axis_clk or negedge aresetn) begin
    if (!aresetn) begin
      state_r     <= ST_IDLE;
      gap_cnt_r   <= 8'd0;
      mod_r       <= '0;
      addr_r      <= '0;
      data_r      <= '0;
      tdata_r     <= '0;
      tuser_r     <= '0;
      tkeep_r     <= '0;
      tvalid_r    <= 1'b0;
      tlast_r     <= 1'b0;
      cfg_ready_r <= 1'b1;
      busy_r      <= 1'b0;
      pkt_cnt_r   <= 16'd0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (accept_s) begin
            mod_r       <= i_cfg_mod_id;
            addr_r      <= i_cfg_addr;
            data_r      <= i_cfg_data;
            tdata_r     <= CTRL_HDR;
            tuser_r     <= HDR_TUSER;
            tkeep_r     <= '1;
            tvalid_r    <= 1'b1;
            tlast_r     <= 1'b0;
            cfg_ready_r <= 1'b0;
            busy_r      <= 1'b1;
            state_r     <= ST_HDR;
          end
        end
        ST_HDR: begin
          if (hs_s) begin
            tdata_r <= mod_beat_s;
            tuser_r <= '0;
            state_r <= ST_MOD;
          end
        end
        ST_MOD: begin
          if (hs_s) begin
            tdata_r <= dhi_beat_s;
            state_r <= ST_DHI;
          end
        end
        ST_DHI: begin
          if (hs_s) begin
            tdata_r <= dlo_beat_s;
            tlast_r <= 1'b1;
            state_r <= ST_DLO;
          end
        end
        ST_DLO: begin
          if (hs_s) begin
            tdata_r   <= '0;
            tkeep_r   <= '0;
            tvalid_r  <= 1'b0;
            tlast_r   <= 1'b0;
            pkt_cnt_r <= pkt_cnt_r + 16'd1;
            gap_cnt_r <= GAP_LOAD;
            state_r   <= ST_GAP;
          end
        end
        ST_GAP: begin
          if (gap_cnt_r == 8'd0) begin
            cfg_ready_r <= 1'b1;
            busy_r      <= 1'b0;
            state_r     <= ST_IDLE;
          end else begin
            gap_cnt_r <= gap_cnt_r - 8'd1;
          end
        end
        default: begin
          tdata_r     <= '0;
          tuser_r     <= '0;
          tkeep_r     <= '0;
          tvalid_r    <= 1'b0;
          tlast_r     <= 1'b0;
          cfg_ready_r <= 1'b1;
          busy_r      <= 1'b0;
          state_r     <= ST_IDLE;
        end
      endcase
    end
  end

  assign ctrl_m_axis.tdata  = tdata_r;
  assign ctrl_m_axis.tuser  = tuser_r;
  assign ctrl_m_axis.tkeep  = tkeep_r;
  assign ctrl_m_axis.tvalid = tvalid_r;
  assign ctrl_m_axis.tlast  = tlast_r;
  assign o_cfg_ready        = cfg_ready_r;
  assign o_busy             = busy_r;
  assign o_pkt_cnt          = pkt_cnt_r;

endmodule

// File: tb/tb_parser_cfg_pkt_gen.sv
// Self-checking bench for parser_cfg_pkt_gen: randomized requests checked
// against a byte-layout reference model of the 4-beat control packet.
module tb_parser_cfg_pkt_gen;

  localparam int IFG = 2;

  typedef struct packed {
    logic [255:0] d;
    logic [127:0] u;
    logic         l;
  } beat_t;

  logic         clk = 1'b0;
  logic         aresetn;
  logic         cfg_valid;
  logic         cfg_ready;
  logic [3:0]   cfg_mod;
  logic [8:0]   cfg_addr;
  logic [383:0] cfg_data;
  logic         busy;
  logic [15:0]  pkt_cnt;
  logic         ready_rand;
  logic         ready_force;
  logic         rand_bit = 1'b1;

  int tests_run    = 0;
  int tests_failed = 0;
  int cyc          = 0;
  int proto_err    = 0;
  int exp_cnt      = 0;

  beat_t beats[$];
  int    beat_cyc[$];
  beat_t cur_beat;
  beat_t prev_beat;
  logic  prev_stall = 1'b0;
  logic  prev_mid   = 1'b0;

  parser_cfg_pkt_gen_if #(.DATA_WIDTH(256), .TUSER_WIDTH(128)) axis_if ();

  assign axis_if.tready = ready_rand ? rand_bit : ready_force;
  assign cur_beat = {axis_if.tdata, axis_if.tuser, axis_if.tlast};

  parser_cfg_pkt_gen #(.IFG_CYCLES(IFG)) dut (
    .axis_clk    (clk),
    .aresetn     (aresetn),
    .i_cfg_valid (cfg_valid),
    .o_cfg_ready (cfg_ready),
    .i_cfg_mod_id(cfg_mod),
    .i_cfg_addr  (cfg_addr),
    .i_cfg_data  (cfg_data),
    .ctrl_m_axis (axis_if.master),
    .o_busy      (busy),
    .o_pkt_cnt   (pkt_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc      <= cyc + 1;
    rand_bit <= ($urandom_range(0, 3) != 0);
  end

  // Handshake monitor: records beats and flags stall/continuity/tkeep violations.
  always @(negedge clk) begin
    if (!aresetn) begin
      prev_stall <= 1'b0;
      prev_mid   <= 1'b0;
    end else begin
      if ((prev_stall && (axis_if.tvalid !== 1'b1 || cur_beat !== prev_beat)) ||
          (prev_mid && axis_if.tvalid !== 1'b1) ||
          (axis_if.tvalid === 1'b1 && axis_if.tkeep !== 32'hFFFF_FFFF)) begin
        proto_err <= proto_err + 1;
        $display("[TB] protocol violation at cycle %0d", cyc);
      end
      if (axis_if.tvalid === 1'b1 && axis_if.tready === 1'b1) begin
        beats.push_back(cur_beat);
        beat_cyc.push_back(cyc);
      end
      prev_stall <= axis_if.tvalid & ~axis_if.tready;
      prev_mid   <= axis_if.tvalid & axis_if.tready & ~axis_if.tlast;
      prev_beat  <= cur_beat;
    end
  end

  function automatic logic [383:0] rand384();
    logic [383:0] r;
    for (int i = 0; i < 12; i++) r[32*i +: 32] = $urandom;
    return r;
  endfunction

  function automatic logic [255:0] swap_bytes(input logic [255:0] w);
    logic [255:0] r;
    for (int k = 0; k < 32; k++) r[8*k +: 8] = w[255-8*k -: 8];
    return r;
  endfunction

  // Expected beat idx of a packet, from the documented byte layout.
  function automatic beat_t model_beat(input int idx, input logic [3:0] m,
                                       input logic [8:0] a, input logic [383:0] dat);
    beat_t b;
    b = '0;
    case (idx)
      0: b.u[15:0] = 16'd128;
      1: b.d[115:112] = m;
      2: for (int k = 0; k < 32; k++) b.d[8*k +: 8] = dat[383-8*k -: 8];
      3: begin
        b.d[0]    = a[8];
        b.d[15:8] = a[7:0];
        for (int j = 0; j < 16; j++) b.d[16+8*j +: 8] = dat[127-8*j -: 8];
        b.l = 1'b1;
      end
      default: b = '0;
    endcase
    return b;
  endfunction

  task automatic do_reset();
    aresetn     = 1'b0;
    cfg_valid   = 1'b0;
    cfg_mod     = 4'd0;
    cfg_addr    = 9'd0;
    cfg_data    = '0;
    ready_rand  = 1'b0;
    ready_force = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    aresetn = 1'b1;
    beats.delete();
    beat_cyc.delete();
    exp_cnt = 0;
  endtask

  task automatic send(input logic [3:0] m, input logic [8:0] a, input logic [383:0] dat,
                      input bit hold, output int acc);
    @(posedge clk); #1;
    cfg_valid = 1'b1;
    cfg_mod   = m;
    cfg_addr  = a;
    cfg_data  = dat;
    acc = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (cfg_ready === 1'b1) begin
        acc = cyc;
        break;
      end
    end
    tests_run++;
    if (acc < 0) begin
      tests_failed++;
      $display("FAIL accept: o_cfg_ready=%b, required 1 within 40 cycles", cfg_ready);
    end
    @(posedge clk); #1;
    if (!hold) cfg_valid = 1'b0;
    cfg_mod  = 4'($urandom);
    cfg_addr = 9'($urandom);
    cfg_data = rand384();
  endtask

  task automatic collect(input int n, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (beats.size() >= n) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    tests_run++;
    if (!ok) begin
      tests_failed++;
      $display("FAIL collect: got %0d beats, required %0d", beats.size(), n);
    end
  endtask

  task automatic check_pkt(input int base, input logic [3:0] m, input logic [8:0] a,
                           input logic [383:0] dat);
    beat_t e;
    for (int i = 0; i < 4; i++) begin
      e = model_beat(i, m, a, dat);
      tests_run++;
      if (beats[base+i] !== e) begin
        tests_failed++;
        $display("FAIL beat%0d: got d=%h u=%h l=%b, required d=%h u=%h l=%b", i,
                 beats[base+i].d, beats[base+i].u, beats[base+i].l, e.d, e.u, e.l);
      end
    end
  endtask

  task automatic check_cnt();
    tests_run++;
    if (pkt_cnt !== 16'(exp_cnt)) begin
      tests_failed++;
      $display("FAIL pkt_cnt: got %0d, required %0d", pkt_cnt, exp_cnt);
    end
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    tests_run++;
    if ({cfg_ready, busy, pkt_cnt, axis_if.tvalid, axis_if.tlast} !== {1'b1, 1'b0, 16'd0, 1'b0, 1'b0}) begin
      tests_failed++;
      $display("FAIL reset_ctrl: got ready=%b busy=%b cnt=%0d tvalid=%b tlast=%b, required 1 0 0 0 0",
               cfg_ready, busy, pkt_cnt, axis_if.tvalid, axis_if.tlast);
    end
    tests_run++;
    if ({axis_if.tdata, axis_if.tuser, axis_if.tkeep} !== {416{1'b0}}) begin
      tests_failed++;
      $display("FAIL reset_data: got tdata=%h tuser=%h tkeep=%h, required 0",
               axis_if.tdata, axis_if.tuser, axis_if.tkeep);
    end
  endtask

  task automatic test_single();
    logic [383:0] dat;
    int acc;
    bit ok;
    for (int i = 0; i < 48; i++) dat[383-8*i -: 8] = 8'(i + 1);
    do_reset();
    send(4'd1, 9'h025, dat, 1'b0, acc);
    collect(4, ok);
    if (ok) begin
      exp_cnt++;
      check_pkt(0, 4'd1, 9'h025, dat);
      tests_run++;
      if (beat_cyc[0] !== acc + 1 || beat_cyc[3] - beat_cyc[0] !== 3) begin
        tests_failed++;
        $display("FAIL single_timing: got accept=%0d beats %0d..%0d, required beat0=accept+1 and 4 consecutive",
                 acc, beat_cyc[0], beat_cyc[3]);
      end
      tests_run++;
      if ({beats[3].l, beats[2].l, beats[1].l, beats[0].l} !== 4'b1000) begin
        tests_failed++;
        $display("FAIL single_tlast: got %b, required 1000",
                 {beats[3].l, beats[2].l, beats[1].l, beats[0].l});
      end
      tests_run++;
      if ({beats[1].d[115:112], beats[3].d[15:8], beats[3].d[0]} !== {4'd1, 8'h25, 1'b0}) begin
        tests_failed++;
        $display("FAIL single_fields: got mod=%h addr_lo=%h addr8=%b, required 1 25 0",
                 beats[1].d[115:112], beats[3].d[15:8], beats[3].d[0]);
      end
      check_cnt();
      tests_run++;
      if ({busy, cfg_ready, axis_if.tvalid} !== 3'b100) begin
        tests_failed++;
        $display("FAIL single_gap: got busy=%b ready=%b tvalid=%b, required 1 0 0",
                 busy, cfg_ready, axis_if.tvalid);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [383:0] dat;
    logic [3:0] m;
    logic [8:0] a;
    beat_t exp_dhi;
    int acc;
    bit ok;
    do_reset();
    dat = rand384(); m = 4'($urandom); a = 9'($urandom);
    exp_dhi = model_beat(2, m, a, dat);
    send(m, a, dat, 1'b0, acc);
    for (int i = 0; i < 20; i++) begin
      if (beats.size() >= 2) break;
      @(posedge clk); #1;
    end
    ready_force = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      tests_run++;
      if (axis_if.tvalid !== 1'b1 || cur_beat !== exp_dhi) begin
        tests_failed++;
        $display("FAIL stall%0d: got tvalid=%b tdata=%h, required 1 %h",
                 i, axis_if.tvalid, axis_if.tdata, exp_dhi.d);
      end
    end
    @(posedge clk); #1;
    ready_force = 1'b1;
    collect(4, ok);
    if (ok) begin
      exp_cnt++;
      check_pkt(0, m, a, dat);
      tests_run++;
      if (beat_cyc[2] - beat_cyc[1] !== 4) begin
        tests_failed++;
        $display("FAIL stall_len: got %0d, required 4", beat_cyc[2] - beat_cyc[1]);
      end
      repeat (IFG + 3) @(posedge clk);
      #1;
      tests_run++;
      if (beats.size() !== 4) begin
        tests_failed++;
        $display("FAIL bp_handshakes: got %0d, required 4", beats.size());
      end
      check_cnt();
    end
  endtask

  task automatic test_back_to_back();
    logic [383:0] da, db;
    logic [3:0] ma, mb;
    logic [8:0] aa, ab;
    int acc_a, acc_b;
    bit ok;
    do_reset();
    da = rand384(); ma = 4'($urandom); aa = 9'($urandom);
    db = rand384(); mb = 4'($urandom); ab = 9'($urandom);
    send(ma, aa, da, 1'b1, acc_a);
    send(mb, ab, db, 1'b0, acc_b);
    collect(8, ok);
    if (ok) begin
      exp_cnt += 2;
      check_pkt(0, ma, aa, da);
      check_pkt(4, mb, ab, db);
      // tvalid low for the IFG gap plus the accept cycle between packets.
      tests_run++;
      if (acc_b !== beat_cyc[3] + IFG + 1 || beat_cyc[4] - beat_cyc[3] !== IFG + 2) begin
        tests_failed++;
        $display("FAIL b2b_gap: got tlast=%0d accept=%0d beat0=%0d, required accept=tlast+%0d beat0=tlast+%0d",
                 beat_cyc[3], acc_b, beat_cyc[4], IFG + 1, IFG + 2);
      end
      check_cnt();
    end
  endtask

  task automatic test_boundary();
    logic [383:0] dat;
    int acc;
    bit ok;
    do_reset();
    dat = '1;
    send(4'hF, 9'h1FF, dat, 1'b0, acc);
    collect(4, ok);
    if (ok) begin
      exp_cnt++;
      check_pkt(0, 4'hF, 9'h1FF, dat);
      tests_run++;
      if (beats[3].d[0] !== 1'b1 || beats[3].d[15:8] !== 8'hFF || beats[3].d[143:16] !== {128{1'b1}} ||
          beats[3].d[7:1] !== 7'd0 || beats[3].d[255:144] !== {112{1'b0}}) begin
        tests_failed++;
        $display("FAIL boundary_dlo: got %h", beats[3].d);
      end
      tests_run++;
      if (beats[2].d !== {256{1'b1}}) begin
        tests_failed++;
        $display("FAIL boundary_dhi: got %h, required all ones", beats[2].d);
      end
      check_cnt();
    end
  endtask

  task automatic test_reset_mid();
    logic [383:0] dat;
    logic [3:0] m;
    logic [8:0] a;
    int acc;
    bit ok;
    do_reset();
    send(4'd2, 9'h011, rand384(), 1'b0, acc);
    collect(4, ok);
    send(4'd3, 9'h022, rand384(), 1'b0, acc);
    for (int i = 0; i < 20; i++) begin
      if (beats.size() >= 6) break;
      @(posedge clk); #1;
    end
    #1;
    aresetn = 1'b0;
    #1;
    tests_run++;
    if ({axis_if.tvalid, axis_if.tlast, axis_if.tdata, cfg_ready} !== {2'b00, 256'd0, 1'b1}) begin
      tests_failed++;
      $display("FAIL async_reset: got tvalid=%b tlast=%b tdata=%h ready=%b, required 0 0 0 1",
               axis_if.tvalid, axis_if.tlast, axis_if.tdata, cfg_ready);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    aresetn = 1'b1;
    beats.delete();
    beat_cyc.delete();
    exp_cnt = 0;
    @(negedge clk);
    tests_run++;
    if ({cfg_ready, busy, pkt_cnt} !== {1'b1, 1'b0, 16'd0}) begin
      tests_failed++;
      $display("FAIL post_reset: got ready=%b busy=%b cnt=%0d, required 1 0 0", cfg_ready, busy, pkt_cnt);
    end
    dat = rand384(); m = 4'($urandom); a = 9'($urandom);
    send(m, a, dat, 1'b0, acc);
    collect(4, ok);
    if (ok) begin
      exp_cnt++;
      check_pkt(0, m, a, dat);
      check_cnt();
    end
  endtask

  task automatic test_decode();
    logic [383:0] dat;
    logic [255:0] hi, w;
    logic [3:0] m;
    logic [8:0] a;
    int acc, base;
    bit ok;
    do_reset();
    ready_rand = 1'b1;
    for (int n = 0; n < 32; n++) begin
      dat = rand384(); m = 4'($urandom); a = 9'($urandom);
      base = beats.size();
      send(m, a, dat, 1'b0, acc);
      collect(base + 4, ok);
      if (!ok) break;
      exp_cnt++;
      check_pkt(base, m, a, dat);
      hi = swap_bytes(beats[base+2].d);
      w  = swap_bytes(beats[base+3].d);
      tests_run++;
      if ({hi, w[239:112]} !== dat || w[248:240] !== a || beats[base+1].d[115:112] !== m) begin
        tests_failed++;
        $display("FAIL decode%0d: got addr=%h mod=%h, required addr=%h mod=%h (data match=%b)",
                 n, w[248:240], beats[base+1].d[115:112], a, m, {hi, w[239:112]} === dat);
      end
    end
    ready_rand = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check_cnt();
  endtask

  task automatic test_protocol();
    tests_run++;
    if (proto_err !== 0) begin
      tests_failed++;
      $display("FAIL protocol: got %0d violations, required 0", proto_err);
    end
  endtask

  initial begin
    aresetn     = 1'b0;
    cfg_valid   = 1'b0;
    ready_rand  = 1'b0;
    ready_force = 1'b1;
    test_reset();
    test_single();
    test_backpressure();
    test_back_to_back();
    test_boundary();
    test_reset_mid();
    test_decode();
    test_protocol();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
